// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble word,
// RV opcode/funct constants and the fetch FSM state encoding.
package if_fetch_stage_pkg;

  // RV base opcodes and funct3 values referenced by the fetch/decode boundary
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  // addi x0,x0,0 assembled from its fields
  localparam logic [31:0] DEF_NOP_INST = {12'h000, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

  // Fetch FSM encoding
  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_START = S_START,
    ST_FETCH = S_FETCH,
    ST_HOLD  = S_HOLD,
    ST_DRAIN = S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_ifid_pipe_reg.sv
// IF/ID pipeline register: valid/inst/pc with flush (bubble) and load
// controls. Flush beats load; with neither asserted the contents hold.
module ifid_pipe_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int          PC_W     = 64,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [PC_W-1:0] o_pc
);

  logic            r_vld_p1;
  logic [31:0]     r_inst_p1;
  logic [PC_W-1:0] r_pc_p1;

  // IF -> ID boundary: invalid entries always carry NOP/0 so decode sees a clean bubble
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_vld_p1  <= 1'b0;
      r_inst_p1 <= NOP_INST;
      r_pc_p1   <= '0;
    end else if (i_flush) begin
      r_vld_p1  <= 1'b0;
      r_inst_p1 <= NOP_INST;
      r_pc_p1   <= '0;
    end else if (i_load) begin
      r_vld_p1  <= 1'b1;
      r_inst_p1 <= i_inst;
      r_pc_p1   <= i_pc;
    end
  end

  assign o_valid = r_vld_p1;
  assign o_inst  = r_inst_p1;
  assign o_pc    = r_pc_p1;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs one outstanding imem request
// at a time, buffers a word returned under stall, and handles redirects
// including draining a request that was already in flight.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = DEF_NOP_INST
) (
  input  logic                   clk,
  input  logic                   nrst,
  if_fetch_stage_if.master       imem,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   ifid_valid,
  output logic [31:0]            ifid_inst,
  output logic [PC_W-1:0]        ifid_pc
);

  function automatic logic [PC_W-1:0] align4(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_addr;
  logic            r_req;
  logic            r_hold_vld;
  logic [31:0]     r_hold_inst;
  logic [PC_W-1:0] r_hold_pc;

  fetch_state_e    w_nstate;
  logic [PC_W-1:0] w_npc;
  logic [PC_W-1:0] w_naddr;
  logic            w_ld;
  logic            w_fl;
  logic [31:0]     w_ld_inst;
  logic [PC_W-1:0] w_ld_pc;
  logic            w_hold_cap;
  logic            w_hold_clr;

  // Next-state, PC and IF/ID control; redirect overrides everything else
  always_comb begin
    w_nstate   = r_state;
    w_npc      = r_pc;
    w_ld       = 1'b0;
    w_fl       = 1'b0;
    w_ld_inst  = imem.imem_rdata;
    w_ld_pc    = r_pc;
    w_hold_cap = 1'b0;
    w_hold_clr = 1'b0;
    case (r_state)
      ST_START: w_nstate = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ack) begin
          w_npc = r_pc + PC_W'(4);
          if (stall) begin
            w_hold_cap = 1'b1;
            w_nstate   = ST_HOLD;
          end else begin
            w_ld = 1'b1;
          end
        end else if (!stall) begin
          w_fl = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_ld       = r_hold_vld;
          w_ld_inst  = r_hold_inst;
          w_ld_pc    = r_hold_pc;
          w_hold_clr = 1'b1;
          w_nstate   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem.imem_ack) w_nstate = ST_FETCH;
      end
      default: w_nstate = ST_START;
    endcase
    if (redirect) begin
      w_npc      = align4(redirect_pc);
      w_ld       = 1'b0;
      w_fl       = 1'b1;
      w_hold_cap = 1'b0;
      w_hold_clr = 1'b1;
      // A request with no ack yet must still complete before refetching
      w_nstate   = ((r_state == ST_FETCH || r_state == ST_DRAIN) && !imem.imem_ack)
                   ? ST_DRAIN : ST_FETCH;
    end
    // Draining keeps presenting the old address until its ack arrives
    w_naddr = (w_nstate == ST_DRAIN) ? r_addr : w_npc;
  end

  // FSM, PC, request address and registered request strobe
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_START;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_hold_vld <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_addr  <= w_naddr;
      r_req   <= (w_nstate == ST_FETCH) || (w_nstate == ST_DRAIN);
      if (w_hold_cap)      r_hold_vld <= 1'b1;
      else if (w_hold_clr) r_hold_vld <= 1'b0;
    end
  end

  // Hold buffer payload; only meaningful while r_hold_vld is set
  always_ff @(posedge clk) begin
    if (w_hold_cap) begin
      r_hold_inst <= imem.imem_rdata;
      r_hold_pc   <= r_pc;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;

  ifid_pipe_reg #(
    .PC_W     (PC_W),
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clk     (clk),
    .nrst    (nrst),
    .i_load  (w_ld),
    .i_flush (w_fl),
    .i_inst  (w_ld_inst),
    .i_pc    (w_ld_pc),
    .o_valid (ifid_valid),
    .o_inst  (ifid_inst),
    .o_pc    (ifid_pc)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed cycles push the expected
// IF/ID word when an ack is accepted; a negedge monitor pops and compares
// whenever decode consumes (or a redirect kills) a valid IF/ID entry.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [63:0] ifid_pc;

  logic        nrst2 = 1'b0;
  logic        ifid_valid2;
  logic [31:0] ifid_inst2;
  logic [63:0] ifid_pc2;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;

  if_fetch_stage_if #(.PC_W(64)) bus ();
  if_fetch_stage_if #(.PC_W(64)) bus2 ();

  if_fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .nrst(nrst), .imem(bus.master), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc)
  );

  if_fetch_stage #(.PC_W(64), .RESET_PC(TOP_PC)) dut2 (
    .clk(clk), .nrst(nrst2), .imem(bus2.master), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(64'h0),
    .ifid_valid(ifid_valid2), .ifid_inst(ifid_inst2), .ifid_pc(ifid_pc2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    if (a == 64'h4) return 32'h00A00113;
    return {a[19:0], 12'h093};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs, push expectation for an accepted ack, check the bus
  task automatic step(input logic a, input logic s, input logic r, input logic [63:0] rpc,
                      input logic disc, input logic ereq, input logic [63:0] eaddr);
    bus.imem_ack   = a;
    bus.imem_rdata = memf(bus.imem_addr);
    stall          = s;
    redirect       = r;
    redirect_pc    = rpc;
    if (a && !r && !disc) q.push_back('{pc: eaddr, inst: memf(eaddr)});
    @(negedge clk);
    chk("imem_req", {63'h0, bus.imem_req}, {63'h0, ereq});
    if (ereq) chk("imem_addr", bus.imem_addr, eaddr);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
  endtask

  // Monitor: consume IF/ID entries and check bubbles
  always @(negedge clk) begin
    if (nrst) begin
      if (ifid_valid && (!stall || redirect)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: ifid_pc 0x%0h with nothing expected", ifid_pc);
        end else begin
          e = q.pop_front();
          chk("sb_pc", ifid_pc, e.pc);
          chk("sb_inst", {32'h0, ifid_inst}, {32'h0, e.inst});
        end
      end else if (!ifid_valid) begin
        chk("bubble_inst", {32'h0, ifid_inst}, {32'h0, NOP});
        chk("bubble_pc", ifid_pc, 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus2.imem_ack   = 1'b0;
    bus2.imem_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
    chk("rst_valid", {63'h0, ifid_valid}, 64'h0);
    chk("rst_inst", {32'h0, ifid_inst}, {32'h0, NOP});
    chk("rst_pc", ifid_pc, 64'h0);
    nrst = 1'b1;

    // a, s, r, rpc, disc, ereq, eaddr
    step(0, 0, 0, 64'h0,   0, 0, 64'h0);    // START
    step(1, 0, 0, 64'h0,   0, 1, 64'h0);    // ack pc 0
    step(1, 0, 0, 64'h0,   0, 1, 64'h4);    // ack pc 4, IF/ID=pc0
    step(1, 1, 0, 64'h0,   0, 1, 64'h8);    // ack pc 8 under stall -> HOLD
    step(0, 1, 0, 64'h0,   0, 0, 64'h0);    // HOLD, frozen at pc 4
    step(0, 1, 0, 64'h0,   0, 0, 64'h0);
    step(0, 0, 0, 64'h0,   0, 0, 64'h0);    // stall drops, buffer -> IF/ID
    step(0, 0, 0, 64'h0,   0, 1, 64'hC);    // ifid_pc 8, fetching 12
    step(1, 0, 0, 64'h0,   0, 1, 64'hC);
    step(0, 0, 1, 64'h103, 0, 1, 64'h10);   // redirect while 0x10 pending
    step(0, 0, 0, 64'h0,   0, 1, 64'h10);   // DRAIN old address
    step(1, 0, 0, 64'h0,   1, 1, 64'h10);   // ack discarded
    step(0, 0, 0, 64'h0,   0, 1, 64'h100);
    step(1, 0, 0, 64'h0,   0, 1, 64'h100);
    step(1, 1, 1, 64'h200, 1, 1, 64'h104);  // redirect+stall+ack: flush wins
    step(0, 0, 0, 64'h0,   0, 1, 64'h200);
    step(1, 0, 0, 64'h0,   0, 1, 64'h200);
    step(0, 0, 1, 64'h300, 0, 1, 64'h204);  // redirect -> DRAIN
    step(0, 0, 1, 64'h402, 0, 1, 64'h204);  // redirect again during DRAIN
    step(1, 0, 0, 64'h0,   1, 1, 64'h204);
    step(1, 0, 0, 64'h0,   0, 1, 64'h400);
    step(0, 1, 0, 64'h0,   0, 1, 64'h404);  // no ack, stall: IF/ID unchanged
    step(1, 0, 0, 64'h0,   0, 1, 64'h404);
    step(0, 0, 0, 64'h0,   0, 1, 64'h408);
    chk("queue_empty_1", 64'(q.size()), 64'h0);

    // Asynchronous reset in the middle of FETCH, no clock edge
    nrst = 1'b0;
    #1;
    chk("arst_req", {63'h0, bus.imem_req}, 64'h0);
    chk("arst_valid", {63'h0, ifid_valid}, 64'h0);
    chk("arst_inst", {32'h0, ifid_inst}, {32'h0, NOP});
    chk("arst_pc", ifid_pc, 64'h0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step(0, 0, 0, 64'h0,   0, 0, 64'h0);    // START again
    step(1, 0, 0, 64'h0,   0, 1, 64'h0);    // refetch from RESET_PC
    step(0, 0, 0, 64'h0,   0, 1, 64'h4);
    chk("queue_empty_2", 64'(q.size()), 64'h0);

    // PC wrap from the top of the address space
    nrst2 = 1'b1;
    @(negedge clk);
    chk("wrap_start_req", {63'h0, bus2.imem_req}, 64'h0);
    @(negedge clk);
    chk("wrap_req", {63'h0, bus2.imem_req}, 64'h1);
    chk("wrap_addr", bus2.imem_addr, TOP_PC);
    bus2.imem_ack   = 1'b1;
    bus2.imem_rdata = 32'h00500093;
    @(posedge clk);
    #1;
    bus2.imem_ack = 1'b0;
    chk("wrap_next_addr", bus2.imem_addr, 64'h0);
    chk("wrap_ifid_valid", {63'h0, ifid_valid2}, 64'h1);
    chk("wrap_ifid_pc", ifid_pc2, TOP_PC);
    chk("wrap_ifid_inst", {32'h0, ifid_inst2}, 64'h00500093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
